// File: rtl/newton_solver_param_if.sv
// ============================================================================
// Module      : newton_solver_param_if
// Description : Coefficient stream, result stream and status bundle for the
//               Newton-Raphson quadratic root finder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface newton_solver_param_if #(
    parameter int W        = 8,
    parameter int MAX_ITER = 8
);
    localparam int IW = $clog2(MAX_ITER + 1);

    logic                 in_valid;
    logic signed [W-1:0]  in_data;
    logic                 in_ready;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  root;
    logic [1:0]           status;
    logic [IW-1:0]        iters;
    logic                 busy;

    modport master (
        output in_valid, in_data, abort, out_ready,
        input  in_ready, out_valid, root, status, iters, busy
    );

    modport slave (
        input  in_valid, in_data, abort, out_ready,
        output in_ready, out_valid, root, status, iters, busy
    );
endinterface

`default_nettype wire

// File: rtl/newton_solver_param.sv
// ============================================================================
// Module      : newton_solver_param
// Description : Iterative integer Newton-Raphson solver for a*x^2+b*x+c = 0,
//               loaded as four signed words (a, b, c, x0) over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module newton_solver_param #(
    parameter int W        = 8,
    parameter int MAX_ITER = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    newton_solver_param_if.slave   bus
);
    localparam int IW   = $clog2(MAX_ITER + 1);
    localparam int c_TW = 3 * W + 2;
    localparam int c_BW = 2 * W + 2;
    localparam int c_NW = 3 * W + 3;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_EVAL   = 3'd2;
    localparam logic [2:0] c_UPDATE = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam logic [1:0] c_ST_CONV  = 2'd0;
    localparam logic [1:0] c_ST_DIV0  = 2'd1;
    localparam logic [1:0] c_ST_OVF   = 2'd2;
    localparam logic [1:0] c_ST_MAXIT = 2'd3;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nx;
    logic [1:0]              r_idx;
    logic signed [W-1:0]     r_a;
    logic signed [W-1:0]     r_b;
    logic signed [W-1:0]     r_c;
    logic signed [W-1:0]     r_x;
    logic signed [W-1:0]     r_root;
    logic signed [c_TW-1:0]  r_top;
    logic signed [c_BW-1:0]  r_bot;
    logic [1:0]              r_status;
    logic [IW-1:0]           r_iters;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;

    logic                    w_accept;
    logic signed [c_TW-1:0]  w_at;
    logic signed [c_TW-1:0]  w_bt;
    logic signed [c_TW-1:0]  w_ct;
    logic signed [c_TW-1:0]  w_xt;
    logic signed [c_BW-1:0]  w_ab;
    logic signed [c_BW-1:0]  w_bb;
    logic signed [c_BW-1:0]  w_xb;
    logic signed [c_TW-1:0]  w_top;
    logic signed [c_BW-1:0]  w_bot;
    logic                    w_bot_zero;
    logic signed [c_TW-1:0]  w_den;
    logic signed [c_TW-1:0]  w_q;
    logic signed [c_NW-1:0]  w_nx;
    logic                    w_nx_fits;
    logic signed [W-1:0]     w_nx_w;
    logic [IW-1:0]           w_iters_inc;
    logic                    w_last_iter;
    logic                    w_stop;

    assign w_accept = bus.in_valid & r_in_ready;

    // Operands are sign-extended up front so products never wrap for any W-bit input.
    assign w_at  = {{(c_TW-W){r_a[W-1]}}, r_a};
    assign w_bt  = {{(c_TW-W){r_b[W-1]}}, r_b};
    assign w_ct  = {{(c_TW-W){r_c[W-1]}}, r_c};
    assign w_xt  = {{(c_TW-W){r_x[W-1]}}, r_x};
    assign w_ab  = {{(c_BW-W){r_a[W-1]}}, r_a};
    assign w_bb  = {{(c_BW-W){r_b[W-1]}}, r_b};
    assign w_xb  = {{(c_BW-W){r_x[W-1]}}, r_x};
    assign w_top = w_at * w_xt * w_xt + w_bt * w_xt + w_ct;
    assign w_bot = (w_ab + w_ab) * w_xb + w_bb;

    // Divisor forced to 1 when bot is zero; the result is then ignored.
    assign w_bot_zero  = (r_bot == '0);
    assign w_den       = w_bot_zero ? {{(c_TW-1){1'b0}}, 1'b1}
                                    : {{(c_TW-c_BW){r_bot[c_BW-1]}}, r_bot};
    assign w_q         = r_top / w_den;
    assign w_nx        = {{(c_NW-W){r_x[W-1]}}, r_x} - {{(c_NW-c_TW){w_q[c_TW-1]}}, w_q};
    assign w_nx_fits   = (w_nx == {{(c_NW-W){w_nx[W-1]}}, w_nx[W-1:0]});
    assign w_nx_w      = w_nx[W-1:0];
    assign w_iters_inc = r_iters + IW'(1);
    assign w_last_iter = (w_iters_inc == IW'(MAX_ITER));
    assign w_stop      = w_bot_zero || !w_nx_fits || (w_nx_w == r_x) || w_last_iter;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_state_nx = c_LOAD;
            c_LOAD:   if (w_accept && r_idx == 2'd3) w_state_nx = c_EVAL;
            c_EVAL:   w_state_nx = c_UPDATE;
            c_UPDATE: w_state_nx = w_stop ? c_DONE : c_EVAL;
            c_DONE:   if (r_out_valid && bus.out_ready) w_state_nx = c_IDLE;
            default:  w_state_nx = c_IDLE;
        endcase
        if (bus.abort) w_state_nx = c_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_idx       <= 2'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_x         <= '0;
            r_top       <= '0;
            r_bot       <= '0;
            r_root      <= '0;
            r_status    <= c_ST_CONV;
            r_iters     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            // Handshake flags are registered from the next state so they are glitch-free.
            r_in_ready  <= (w_state_nx == c_IDLE) || (w_state_nx == c_LOAD);
            r_out_valid <= (w_state_nx == c_DONE);
            r_busy      <= (w_state_nx != c_IDLE);
            if (bus.abort) begin
                r_idx <= 2'd0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_accept) begin
                            r_a   <= bus.in_data;
                            r_idx <= 2'd1;
                        end
                    end
                    c_LOAD: begin
                        if (w_accept) begin
                            case (r_idx)
                                2'd1:    r_b <= bus.in_data;
                                2'd2:    r_c <= bus.in_data;
                                default: begin
                                    r_x     <= bus.in_data;
                                    r_iters <= '0;
                                end
                            endcase
                            r_idx <= (r_idx == 2'd3) ? 2'd0 : r_idx + 2'd1;
                        end
                    end
                    c_EVAL: begin
                        r_top <= w_top;
                        r_bot <= w_bot;
                    end
                    c_UPDATE: begin
                        r_iters <= w_iters_inc;
                        if (w_bot_zero) begin
                            r_root   <= r_x;
                            r_status <= c_ST_DIV0;
                        end else if (!w_nx_fits) begin
                            r_root   <= r_x;
                            r_status <= c_ST_OVF;
                        end else if (w_nx_w == r_x) begin
                            r_root   <= w_nx_w;
                            r_status <= c_ST_CONV;
                        end else if (w_last_iter) begin
                            r_root   <= w_nx_w;
                            r_status <= c_ST_MAXIT;
                        end else begin
                            r_x <= w_nx_w;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.root      = r_root;
    assign bus.status    = r_status;
    assign bus.iters     = r_iters;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire
